// File: rtl/fsm_seq_gen.sv
// Serial pattern transmitter: sends pattern[len-1:0] MSB-first, reps times, with gap idle cycles between repetitions.
// Optional per-repetition odd-parity bit when SEQ_GEN_PARITY_EN is defined.
module fsm_seq_gen #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [PAT_W-1:0]               pattern,
  input  logic [$clog2(PAT_W):0]         len,
  input  logic [REP_W-1:0]               reps,
  input  logic [GAP_W-1:0]               gap,
  input  logic                           abort,
  output logic                           x,
  output logic                           valid,
  output logic                           busy,
  output logic                           done
);

  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef SEQ_GEN_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             x_q, x_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic             rep_end;
  logic [LEN_W-1:0] len_c;
  logic [PAT_W-1:0] pat_c;

  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
    logic [PAT_W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // Bits above len are cleared at capture so the parity reduce sees only sent bits.
  function automatic logic [PAT_W-1:0] mask_of(input logic [LEN_W-1:0] l);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  assign len_c = (len > PAT_W_L) ? PAT_W_L : len;
  assign pat_c = pattern & mask_of(len_c);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    x_d     = 1'b0;
    rep_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pat_d = pat_c;
          len_d = len_c;
          rep_d = (reps == '0) ? REP_ONE : reps;
          gap_d = gap;
          if (len_c == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
            idx_d   = len_c - LEN_ONE;
            x_d     = bit_at(pat_c, len_c - LEN_ONE);
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - LEN_ONE;
          x_d   = bit_at(pat_q, idx_q - LEN_ONE);
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PARITY;
          x_d     = ~^pat_q;
`else
          rep_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PARITY: begin
        if (abort) state_d = S_IDLE;
        else       rep_end = 1'b1;
      end
`endif
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gcnt_q <= GAP_ONE) begin
          state_d = S_SHIFT;
          idx_d   = len_q - LEN_ONE;
          x_d     = bit_at(pat_q, len_q - LEN_ONE);
        end else begin
          gcnt_d = gcnt_q - GAP_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // End of a repetition: another rep (after optional gap) or finish.
    if (rep_end) begin
      if (rep_q > REP_ONE) begin
        rep_d = rep_q - REP_ONE;
        if (gap_q != '0) begin
          state_d = S_GAP;
          gcnt_d  = gap_q;
        end else begin
          state_d = S_SHIFT;
          idx_d   = len_q - LEN_ONE;
          x_d     = bit_at(pat_q, len_q - LEN_ONE);
        end
      end else begin
        state_d = S_DONE;
      end
    end

`ifdef SEQ_GEN_PARITY_EN
    valid_d = (state_d == S_SHIFT) || (state_d == S_PARITY);
    busy_d  = (state_d == S_SHIFT) || (state_d == S_PARITY) || (state_d == S_GAP);
`else
    valid_d = (state_d == S_SHIFT);
    busy_d  = (state_d == S_SHIFT) || (state_d == S_GAP);
`endif
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      gcnt_q  <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed vector bench for fsm_seq_gen; each record holds one cycle of inputs and the {x,valid,busy,done} expected after that edge.
module tb_fsm_seq_gen;
  localparam int PAT_W = 8;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [REP_W-1:0] reps = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             x, valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int tid   = 0;

  typedef struct {
    int         id;
    logic       st;
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       ab;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  fsm_seq_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .gap(gap), .abort(abort),
    .x(x), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic v(input logic st, input logic [7:0] p, input logic [3:0] l,
                   input logic [3:0] r, input logic [3:0] g, input logic ab,
                   input logic [3:0] e);
    vec_t t;
    t.id = tid; t.st = st; t.pat = p; t.len = l; t.reps = r; t.gap = g; t.ab = ab; t.exp = e;
    tbl.push_back(t);
  endtask

  // Busy data bits, MSB of the n-bit field first; inputs scrambled to show the shadow copies are used.
  task automatic bits(input logic [15:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) v(1'b0, 8'hFF, 4'd1, 4'd15, 4'd15, 1'b0, {b[i], 3'b110});
  endtask

  task automatic gaps(input int n);
    for (int i = 0; i < n; i++) v(1'b0, 8'h55, 4'd3, 4'd9, 4'd1, 1'b0, 4'b0010);
  endtask

  task automatic done_e();
    v(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0001);
  endtask

  task automatic idle();
    v(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0000);
  endtask

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: x/valid/busy/done got %b required %b", nm, got, exp);
    end
  endtask

  initial begin
`ifdef SEQ_GEN_PARITY_EN
    tid = 11; v(1'b1, 8'h0B, 4'd4, 4'd1, 4'd0, 1'b0, 4'b1110); bits(16'b011, 3); bits(16'b0, 1); done_e(); idle();
    tid = 12; v(1'b1, 8'h09, 4'd4, 4'd1, 4'd0, 1'b0, 4'b1110); bits(16'b001, 3); bits(16'b1, 1); done_e(); idle();
    tid = 13; v(1'b1, 8'hFF, 4'd0, 4'd1, 4'd0, 1'b0, 4'b0001); idle();
    tid = 14; v(1'b1, 8'h02, 4'd2, 4'd2, 4'd1, 1'b0, 4'b1110); bits(16'b0, 1); bits(16'b0, 1);
              gaps(1); bits(16'b10, 2); bits(16'b0, 1); done_e(); idle();
`else
    tid = 1;  v(1'b1, 8'hB2, 4'd8, 4'd1, 4'd0, 1'b0, 4'b1110); bits(16'b0110010, 7); done_e(); idle();
    tid = 2;  v(1'b1, 8'h0D, 4'd4, 4'd3, 4'd2, 1'b0, 4'b1110); bits(16'b101, 3); gaps(2);
              bits(16'b1101, 4); gaps(2); bits(16'b1101, 4); done_e(); idle();
    tid = 3;  v(1'b1, 8'hA5, 4'd4, 4'd2, 4'd0, 1'b0, 4'b0110); bits(16'b101, 3); bits(16'b0101, 4); done_e(); idle();
    tid = 4;  v(1'b1, 8'h0C, 4'd4, 4'd0, 4'd0, 1'b0, 4'b1110); bits(16'b100, 3); done_e(); idle();
    tid = 5;  v(1'b1, 8'hB2, 4'd8, 4'd1, 4'd0, 1'b0, 4'b1110); bits(16'b01, 2);
              v(1'b0, 8'hB2, 4'd8, 4'd1, 4'd0, 1'b1, 4'b0000);
              v(1'b1, 8'h03, 4'd2, 4'd1, 4'd0, 1'b0, 4'b1110); bits(16'b1, 1); done_e(); idle();
    tid = 6;  v(1'b1, 8'hFF, 4'd0, 4'd3, 4'd2, 1'b0, 4'b0001); idle(); idle();
    tid = 7;  v(1'b1, 8'h96, 4'd12, 4'd1, 4'd0, 1'b0, 4'b1110); bits(16'b0010110, 7); done_e(); idle();
    tid = 8;  v(1'b1, 8'hC3, 4'd3, 4'd1, 4'd0, 1'b0, 4'b0110);
              v(1'b1, 8'hFF, 4'd8, 4'd1, 4'd0, 1'b0, 4'b1110);
              v(1'b1, 8'hFF, 4'd8, 4'd1, 4'd0, 1'b0, 4'b1110);
              v(1'b1, 8'hFF, 4'd8, 4'd1, 4'd0, 1'b0, 4'b0001);
              v(1'b1, 8'hFF, 4'd8, 4'd1, 4'd0, 1'b0, 4'b0000);
              idle();
    tid = 9;  v(1'b1, 8'hFF, 4'd8, 4'd1, 4'd0, 1'b1, 4'b0000); idle();
    tid = 10; v(1'b1, 8'h01, 4'd1, 4'd15, 4'd0, 1'b0, 4'b1110); bits(16'h3FFF, 14); done_e(); idle();
`endif

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1 check("reset_hold", {x, valid, busy, done}, 4'b0000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("reset_release", {x, valid, busy, done}, 4'b0000);

    foreach (tbl[k]) begin
      @(negedge clk);
      start = tbl[k].st; pattern = tbl[k].pat; len = tbl[k].len;
      reps = tbl[k].reps; gap = tbl[k].gap; abort = tbl[k].ab;
      @(posedge clk);
      #1 check($sformatf("t%0d_vec%0d", tbl[k].id, k), {x, valid, busy, done}, tbl[k].exp);
    end

    // Asynchronous reset in the middle of a transfer: outputs clear at once and no done follows.
    @(negedge clk);
    start = 1'b1; pattern = 8'hB2; len = 4'd8; reps = 4'd2; gap = 4'd0; abort = 1'b0;
    @(posedge clk);
    #1 check("rst_mid_pre", {x, valid, busy, done}, 4'b1110);
    @(negedge clk) start = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_mid_async", {x, valid, busy, done}, 4'b0000);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("rst_mid_after%0d", i), {x, valid, busy, done}, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
